// File: rtl/alu_status_capture_pkg.sv
// Shared definitions for the ALU status capture block: op codes,
// flag bit positions and the capture FSM state encoding.
package alu_status_capture_pkg;

   // Operation codes as produced by the ALU (stored, never decoded here)
   localparam logic [2:0] OP_SOMA = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MULT = 3'b101;

   // Bit positions inside the 4-bit flag vector {Error, Overflow, Negative, Zero}
   localparam int FLAG_ERR  = 3;
   localparam int FLAG_OVF  = 2;
   localparam int FLAG_NEG  = 1;
   localparam int FLAG_ZERO = 0;

   // Capture FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_HOLD     = 2'b01,
      ST_ERR_HOLD = 2'b10,
      ST_LOCK     = 2'b11
   } state_t;

endpackage : alu_status_capture_pkg

// File: rtl/alu_status_capture_sat_counter8.sv
// sat_counter8: 8-bit up-counter that sticks at 255 and has a
// synchronous clear. Clear wins over increment.
module sat_counter8 (
   input  logic       clk,
   input  logic       srst,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] count
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 8'd0;
      end else if (inc && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter8

// File: rtl/alu_status_capture.sv
// alu_status_capture: captures ALU result/flags/op records behind a
// valid/ready handshake, keeps sticky overflow/error flags and a
// saturating overflow counter, and locks after an error record until Clear.
module alu_status_capture
   import alu_status_capture_pkg::*;
(
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] In_Result,
   input  logic [3:0] In_Flags,
   input  logic [2:0] In_Op,
   input  logic       In_Valid,
   output logic       In_Ready,
   output logic [7:0] Out_Result,
   output logic [3:0] Out_Flags,
   output logic [2:0] Out_Op,
   output logic       Out_Valid,
   input  logic       Out_Ready,
   input  logic       Clear,
   output logic       Sticky_Ovf,
   output logic       Sticky_Err,
   output logic [7:0] Ovf_Count
);

   state_t     state_q, state_d;
   logic [7:0] result_q, result_d;
   logic [3:0] flags_q, flags_d;
   logic [2:0] op_q, op_d;
   logic       out_valid_q, out_valid_d;
   logic       sticky_ovf_q, sticky_ovf_d;
   logic       sticky_err_q, sticky_err_d;
   logic       in_ready;
   logic       capture;

   // Ready and next-state logic; Clear forces IDLE and blocks capture
   always_comb begin
      in_ready = 1'b0;
      state_d  = state_q;
      if (!Reset && !Clear) begin
         unique case (state_q)
            ST_IDLE:     in_ready = 1'b1;
            ST_HOLD:     in_ready = Out_Ready;
            default:     in_ready = 1'b0;
         endcase
      end
      capture = In_Valid & in_ready;

      if (Clear) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (capture) begin
                  state_d = In_Flags[FLAG_ERR] ? ST_ERR_HOLD : ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (Out_Ready) begin
                  if (capture) begin
                     state_d = In_Flags[FLAG_ERR] ? ST_ERR_HOLD : ST_HOLD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_ERR_HOLD: begin
               if (Out_Ready) begin
                  state_d = ST_LOCK;
               end
            end
            ST_LOCK: state_d = ST_LOCK;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Data, valid and sticky next values
   always_comb begin
      result_d     = result_q;
      flags_d      = flags_q;
      op_d         = op_q;
      sticky_ovf_d = sticky_ovf_q;
      sticky_err_d = sticky_err_q;
      out_valid_d  = (state_d == ST_HOLD) || (state_d == ST_ERR_HOLD);
      if (capture) begin
         result_d = In_Result;
         flags_d  = In_Flags;
         op_d     = In_Op;
      end
      if (Clear) begin
         sticky_ovf_d = 1'b0;
         sticky_err_d = 1'b0;
      end else if (capture) begin
         sticky_ovf_d = sticky_ovf_q | In_Flags[FLAG_OVF];
         sticky_err_d = sticky_err_q | In_Flags[FLAG_ERR];
      end
   end

   // State and output registers; reset discards any pending record
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         result_q     <= 8'd0;
         flags_q      <= 4'd0;
         op_q         <= 3'd0;
         out_valid_q  <= 1'b0;
         sticky_ovf_q <= 1'b0;
         sticky_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         result_q     <= result_d;
         flags_q      <= flags_d;
         op_q         <= op_d;
         out_valid_q  <= out_valid_d;
         sticky_ovf_q <= sticky_ovf_d;
         sticky_err_q <= sticky_err_d;
      end
   end

   sat_counter8 u_ovf_count (
      .clk   (Clk),
      .srst  (Reset),
      .clr   (Clear),
      .inc   (capture & In_Flags[FLAG_OVF]),
      .count (Ovf_Count)
   );

   assign In_Ready   = in_ready;
   assign Out_Result = result_q;
   assign Out_Flags  = flags_q;
   assign Out_Op     = op_q;
   assign Out_Valid  = out_valid_q;
   assign Sticky_Ovf = sticky_ovf_q;
   assign Sticky_Err = sticky_err_q;

endmodule : alu_status_capture

// File: tb/tb_alu_status_capture.sv
// Directed testbench for alu_status_capture with hand-computed expectations.
module tb_alu_status_capture;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] In_Result;
   logic [3:0] In_Flags;
   logic [2:0] In_Op;
   logic       In_Valid;
   logic       In_Ready;
   logic [7:0] Out_Result;
   logic [3:0] Out_Flags;
   logic [2:0] Out_Op;
   logic       Out_Valid;
   logic       Out_Ready;
   logic       Clear;
   logic       Sticky_Ovf;
   logic       Sticky_Err;
   logic [7:0] Ovf_Count;

   int tests = 0;
   int fails = 0;

   alu_status_capture dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .In_Result  (In_Result),
      .In_Flags   (In_Flags),
      .In_Op      (In_Op),
      .In_Valid   (In_Valid),
      .In_Ready   (In_Ready),
      .Out_Result (Out_Result),
      .Out_Flags  (Out_Flags),
      .Out_Op     (Out_Op),
      .Out_Valid  (Out_Valid),
      .Out_Ready  (Out_Ready),
      .Clear      (Clear),
      .Sticky_Ovf (Sticky_Ovf),
      .Sticky_Err (Sticky_Err),
      .Ovf_Count  (Ovf_Count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge; inputs change and outputs are sampled 1ns later
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset = 1'b1; Clear = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
      In_Result = 8'h00; In_Flags = 4'h0; In_Op = 3'd0;

      // Reset state (inputs noisy to prove Reset overrides them)
      In_Valid = 1'b1; Out_Ready = 1'b1; Clear = 1'b1; In_Result = 8'hEE; In_Flags = 4'hF;
      step(); step();
      check("rst_in_ready", In_Ready, 0);
      check("rst_out_valid", Out_Valid, 0);
      check("rst_out_result", Out_Result, 0);
      check("rst_out_flags", Out_Flags, 0);
      check("rst_out_op", Out_Op, 0);
      check("rst_sticky_ovf", Sticky_Ovf, 0);
      check("rst_sticky_err", Sticky_Err, 0);
      check("rst_ovf_count", Ovf_Count, 0);
      $display("[TB] reset checked");

      // Basic capture and hold
      Reset = 1'b0; Clear = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
      #1;
      check("idle_in_ready", In_Ready, 1);
      In_Valid = 1'b1; In_Result = 8'h2C; In_Flags = 4'b0000; In_Op = 3'b000;
      step();
      In_Valid = 1'b0;
      #1;
      check("cap_out_valid", Out_Valid, 1);
      check("cap_out_result", Out_Result, 8'h2C);
      check("hold_in_ready", In_Ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_result", Out_Result, 8'h2C);
         check("hold_valid", Out_Valid, 1);
      end
      Out_Ready = 1'b1;
      #1;
      check("hold_ready_follow", In_Ready, 1);
      step();
      check("drain_out_valid", Out_Valid, 0);
      $display("[TB] capture 0x2C held and drained");

      // Back-to-back capture
      Out_Ready = 1'b0; In_Valid = 1'b1; In_Result = 8'h11; In_Flags = 4'b0000; In_Op = 3'b001;
      step();
      Out_Ready = 1'b1; In_Result = 8'h90; In_Flags = 4'b0110; In_Op = 3'b101;
      step();
      In_Valid = 1'b0;
      check("b2b_out_valid", Out_Valid, 1);
      check("b2b_out_result", Out_Result, 8'h90);
      check("b2b_out_flags", Out_Flags, 4'b0110);
      check("b2b_out_op", Out_Op, 3'b101);
      check("b2b_sticky_ovf", Sticky_Ovf, 1);
      check("b2b_sticky_err", Sticky_Err, 0);
      check("b2b_ovf_count", Ovf_Count, 1);
      step();
      check("b2b_drain_valid", Out_Valid, 0);
      $display("[TB] back-to-back 0x11 -> 0x90 captured");

      // Error capture, lock, clear
      Out_Ready = 1'b0; In_Valid = 1'b1; In_Result = 8'h7F; In_Flags = 4'b1000; In_Op = 3'b011;
      step();
      In_Valid = 1'b0;
      check("err_out_valid", Out_Valid, 1);
      check("err_out_flags", Out_Flags, 4'b1000);
      check("err_sticky_err", Sticky_Err, 1);
      Out_Ready = 1'b1;
      #1;
      check("err_hold_in_ready", In_Ready, 0);
      step();
      check("lock_out_valid", Out_Valid, 0);
      In_Valid = 1'b1; In_Result = 8'hAA; In_Flags = 4'b0100; In_Op = 3'b000;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("lock_in_ready", In_Ready, 0);
         step();
         check("lock_result", Out_Result, 8'h7F);
         check("lock_ovf_count", Ovf_Count, 1);
         check("lock_valid", Out_Valid, 0);
      end
      Clear = 1'b1;
      #1;
      check("clear_in_ready", In_Ready, 0);
      step();
      Clear = 1'b0; In_Valid = 1'b0;
      #1;
      check("clr_sticky_err", Sticky_Err, 0);
      check("clr_sticky_ovf", Sticky_Ovf, 0);
      check("clr_ovf_count", Ovf_Count, 0);
      check("clr_in_ready", In_Ready, 1);
      check("clr_out_valid", Out_Valid, 0);
      check("clr_keeps_result", Out_Result, 8'h7F);
      $display("[TB] error lock released by Clear");

      // Saturation over 260 overflow captures
      Out_Ready = 1'b1; In_Valid = 1'b1; In_Result = 8'h01; In_Flags = 4'b0100; In_Op = 3'b101;
      for (int i = 1; i <= 260; i++) begin
         step();
         check("sat_count", Ovf_Count, (i > 255) ? 255 : i);
      end
      In_Valid = 1'b0;
      step();
      check("sat_hold", Ovf_Count, 255);
      check("sat_sticky_ovf", Sticky_Ovf, 1);
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      check("sat_clear", Ovf_Count, 0);
      $display("[TB] saturation at 255 and clear");

      // Clear and In_Valid together from IDLE
      Out_Ready = 1'b1; In_Valid = 1'b1; In_Result = 8'h33; In_Flags = 4'b0100; In_Op = 3'b001;
      step();
      In_Valid = 1'b0;
      step();
      check("pre_clr_count", Ovf_Count, 1);
      check("pre_clr_valid", Out_Valid, 0);
      Clear = 1'b1; In_Valid = 1'b1; In_Result = 8'h55; In_Flags = 4'b1100;
      #1;
      check("clr_cap_in_ready", In_Ready, 0);
      step();
      Clear = 1'b0; In_Valid = 1'b0;
      check("clr_cap_out_valid", Out_Valid, 0);
      check("clr_cap_result", Out_Result, 8'h33);
      check("clr_cap_count", Ovf_Count, 0);
      check("clr_cap_sticky_err", Sticky_Err, 0);
      $display("[TB] Clear beats In_Valid");

      // Reset during HOLD
      Out_Ready = 1'b0; In_Valid = 1'b1; In_Result = 8'hC3; In_Flags = 4'b0110; In_Op = 3'b101;
      step();
      In_Valid = 1'b0;
      check("mid_hold_valid", Out_Valid, 1);
      Reset = 1'b1;
      step();
      check("mid_rst_in_ready", In_Ready, 0);
      check("mid_rst_valid", Out_Valid, 0);
      check("mid_rst_result", Out_Result, 0);
      check("mid_rst_flags", Out_Flags, 0);
      check("mid_rst_op", Out_Op, 0);
      check("mid_rst_sticky_ovf", Sticky_Ovf, 0);
      check("mid_rst_count", Ovf_Count, 0);
      Reset = 1'b0;
      #1;
      check("post_rst_idle_ready", In_Ready, 1);
      $display("[TB] reset during HOLD discards record");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_alu_status_capture

// File: doc/alu_status_capture.md
ALU_STATUS_CAPTURE -- requirements
Module: alu_status_capture

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 In_Result  input  8  ALU result from the flag generator.
REQ-004 In_Flags  input  4  {Error, Overflow, Negative, Zero} from the flag generator.
REQ-005 In_Op  input  3  operation code that produced In_Result.
REQ-006 In_Valid  input  1  producer asserts when In_Result/In_Flags/In_Op are valid.
REQ-007 In_Ready  output  1  block can capture this cycle (combinational).
REQ-008 Out_Result  output  8  captured result, registered.
REQ-009 Out_Flags  output  4  captured flags, same bit order as In_Flags, registered.
REQ-010 Out_Op  output  3  captured op code, registered.
REQ-011 Out_Valid  output  1  captured record is available downstream.
REQ-012 Out_Ready  input  1  consumer accepts the record when high with Out_Valid.
REQ-013 Clear  input  1  synchronous pulse: clears sticky flags and counter, and unlocks the error lock.
REQ-014 Sticky_Ovf  output  1  set by any captured Overflow=1.
REQ-015 Sticky_Err  output  1  set by any captured Error=1.
REQ-016 Ovf_Count  output  8  count of captures with Overflow=1; saturates at 255.

Function
REQ-017 FSM states: IDLE, HOLD, ERR_HOLD, LOCK.
REQ-018 Capture event = In_Valid & In_Ready; on capture, Out_Result/Out_Flags/Out_Op load the inputs on the next edge.
REQ-019 In_Ready = 0 whenever Reset or Clear is high; otherwise In_Ready = 1 in IDLE, = Out_Ready in HOLD, and = 0 in ERR_HOLD and LOCK.
REQ-020 Out_Valid = 1 in HOLD and ERR_HOLD only.
REQ-021 IDLE: a capture with In_Flags[3]=0 goes to HOLD; a capture with In_Flags[3]=1 goes to ERR_HOLD.
REQ-022 HOLD: Out_Ready=0 keeps the state and the data stable.
REQ-022a HOLD, Out_Ready=1 with no capture: go to IDLE.
REQ-022b HOLD, Out_Ready=1 with a capture in the same cycle: load new data and go to HOLD (Error=0) or ERR_HOLD (Error=1), with no bubble cycle.
REQ-023 ERR_HOLD: Out_Ready=1 goes to LOCK; otherwise stay.
REQ-024 LOCK: stay until Clear, then go to IDLE.
REQ-025 Clear in any state: next state IDLE; Sticky_Ovf, Sticky_Err and Ovf_Count go to 0. Out_Result/Out_Flags/Out_Op keep their values, and Out_Valid drops next cycle.
REQ-026 On capture, Sticky_Ovf |= In_Flags[2] and Sticky_Err |= In_Flags[3].
REQ-027 On capture with In_Flags[2]=1: Ovf_Count increments by 1 if below 255; at 255 it holds.
REQ-028 Clear has priority over a simultaneous In_Valid. The input is not captured, because In_Ready is 0.
REQ-029 Latency: a capture at edge N gives Out_Valid=1 and the new data after edge N; the sticky flags and counter update at the same edge.
REQ-030 In_Op is stored without decoding. Flag semantics are owned by the producer.

Reset
REQ-031 While Reset is high: state IDLE; all outputs 0 (Out_Result, Out_Flags, Out_Op, Out_Valid, In_Ready, Sticky_Ovf, Sticky_Err, Ovf_Count).
REQ-032 Reset overrides Clear, In_Valid and Out_Ready. Reset asserted mid-HOLD or mid-LOCK discards the pending record.
REQ-033 First capture is possible on the first edge after Reset deasserts.

Structure
REQ-034 A shared definitions package holds:
- op codes: SOMA=000, SUB=001, MULT=101;
- flag bit indices: ERR=3, OVF=2, NEG=1, ZERO=0;
- FSM state encodings.
REQ-035 One sub-module, sat_counter8 (8-bit saturating up-counter with synchronous clear), implements Ovf_Count.
REQ-036 Target size: 120-400 RTL lines. No latches. All outputs except In_Ready are registered.

Verification
REQ-037 Reset, then In_Valid=1, In_Result=0x2C, In_Flags=0000, In_Op=000, Out_Ready=0 -> next cycle Out_Valid=1, Out_Result=0x2C; data held 3 cycles; Out_Ready=1 -> IDLE, Out_Valid=0.
REQ-038 Back-to-back: HOLD with Out_Ready=1 and In_Valid=1, In_Result=0x90, In_Flags=0110 -> Out_Valid stays 1, Out_Result=0x90, Sticky_Ovf=1, Ovf_Count=1.
REQ-039 Error capture: In_Flags=1000, In_Op=011 -> ERR_HOLD with In_Ready=0; Out_Ready=1 -> LOCK, Out_Valid=0; In_Valid ignored for 5 cycles; Clear -> IDLE, Sticky_Err=0, In_Ready=1.
REQ-040 Saturation: 260 captures with Overflow=1 -> Ovf_Count=255 after the 255th capture and stays 255; Clear -> 0.
REQ-041 Clear and In_Valid in the same cycle from IDLE -> In_Ready=0, no capture, Out_Valid=0 next cycle, Ovf_Count=0.
REQ-042 Reset asserted during HOLD with Out_Valid=1 -> next cycle all outputs 0 and state IDLE.
